load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_mem_pkg.sv | 34 +++
 rtl/lsu_align.sv | 40 ++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_mem_pkg
// Brief   : Shared FSM state type, RV32I memory width codes and decode helpers
// Revision: 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic load_f3_valid(input logic [2:0] f3);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    function automatic logic store_f3_valid(input logic [2:0] f3);
        return (f3 == SB) || (f3 == SH) || (f3 == SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Brief   : Big-endian load extraction and sub-word store merge (combinational)
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_data
);

    // The addressed byte sits in the top lane of the word.
    always_comb begin
        o_load_data = 32'h0;
        case (i_funct3)
            LB:      o_load_data = {{24{i_rd_word[31]}}, i_rd_word[31:24]};
            LBU:     o_load_data = {24'h0, i_rd_word[31:24]};
            LH:      o_load_data = {{16{i_rd_word[31]}}, i_rd_word[31:16]};
            LHU:     o_load_data = {16'h0, i_rd_word[31:16]};
            LW:      o_load_data = i_rd_word;
            default: o_load_data = 32'h0;
        endcase
    end

    always_comb begin
        o_store_data = i_wdata;
        case (i_funct3)
            SB:      o_store_data = {i_wdata[7:0], i_rd_word[23:0]};
            SH:      o_store_data = {i_wdata[15:0], i_rd_word[15:0]};
            default: o_store_data = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : Single-outstanding RV32I load/store unit with sub-word RMW stores
// Revision: 1.0 - initial release
// ============================================================================
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter int MEM_LAST_ADDR = 5120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] c_mem_last = 33'(MEM_LAST_ADDR);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_write;
    logic        r_err;
    logic [31:0] r_rd;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        w_fault;
    logic        w_accept;
    logic [31:0] w_load_data;
    logic [31:0] w_store_data;

    // 33-bit sum so addresses near 2^32 cannot wrap past the bound check.
    assign w_fault  = (({1'b0, req_addr} + 33'd3) > c_mem_last) ||
                      (req_write ? !store_f3_valid(req_funct3) : !load_f3_valid(req_funct3));
    assign w_accept = (r_state == IDLE) && req_valid;
    assign mem_addr = r_addr;

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_rd_word    (r_rd),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_funct3     <= 3'b000;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_rd         <= 32'h0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_write  <= req_write;
                r_err    <= w_fault;
            end
            if (r_state == READ) begin
                r_rd <= mem_rdata;
            end
            // Capture the response so it stays visible until the next one.
            if (r_state == RESP) begin
                r_resp_rdata <= resp_rdata;
                r_resp_err   <= resp_err;
            end
        end
    end

    // Memory strobes are masked by rst so an aborted access never reaches memory.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = 32'h0;
        resp_valid = 1'b0;
        resp_rdata = r_resp_rdata;
        resp_err   = r_resp_err;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_fault) begin
                        w_next = RESP;
                    end else if (req_write && (req_funct3 == SW)) begin
                        w_next = WRITE;
                    end else begin
                        w_next = READ;
                    end
                end
            end
            READ: begin
                mem_read = !rst;
                w_next   = r_write ? WRITE : RESP;
            end
            WRITE: begin
                mem_write = !rst;
                mem_wdata = rst ? 32'h0 : w_store_data;
                w_next    = RESP;
            end
            RESP: begin
                resp_valid = !rst;
                resp_rdata = (r_err || r_write) ? 32'h0 : w_load_data;
                resp_err   = r_err;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Directed and random checks of load_store_unit against a byte model
// Revision: 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int c_last = 5120;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [7:0] tb_mem  [0:c_last];
    logic [7:0] ref_mem [0:c_last];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_LAST_ADDR(c_last)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Big-endian memory with asynchronous read and posedge write.
    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr <= 32'(c_last - 3))
            mem_rdata = {tb_mem[mem_addr], tb_mem[mem_addr + 1], tb_mem[mem_addr + 2], tb_mem[mem_addr + 3]};
    end

    always @(posedge clk) begin
        if (mem_write && (mem_addr <= 32'(c_last - 3))) begin
            tb_mem[mem_addr]     <= mem_wdata[31:24];
            tb_mem[mem_addr + 1] <= mem_wdata[23:16];
            tb_mem[mem_addr + 2] <= mem_wdata[15:8];
            tb_mem[mem_addr + 3] <= mem_wdata[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
    endfunction

    // One request end to end; expectations come from the byte-level model.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic junk);
        logic        fault;
        int          exp_lat, exp_rd, exp_wr, lat, nrd, nwr, ai;
        logic [31:0] exp_rdata, exp_wword, got_wword, rdata_at;
        logic        err_at, both, addr_bad;
        logic [7:0]  b0, b1;

        fault = ((33'(a) + 33'd3) > 33'(c_last)) ||
                (w ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}));
        exp_rdata = 32'h0;
        exp_wword = 32'h0;
        exp_rd = 0;
        exp_wr = 0;
        ai = int'(a);
        if (fault) begin
            exp_lat = 1;
        end else if (!w) begin
            exp_lat = 2;
            exp_rd  = 1;
            b0 = ref_mem[ai];
            b1 = ref_mem[ai + 1];
            case (f3)
                3'd0:    exp_rdata = 32'($signed(b0));
                3'd4:    exp_rdata = {24'h0, b0};
                3'd1:    exp_rdata = 32'($signed({b0, b1}));
                3'd5:    exp_rdata = {16'h0, b0, b1};
                default: exp_rdata = ref_word(ai);
            endcase
        end else begin
            exp_wr = 1;
            if (f3 == 3'd2) begin
                exp_lat = 2;
                ref_mem[ai]     = wd[31:24];
                ref_mem[ai + 1] = wd[23:16];
                ref_mem[ai + 2] = wd[15:8];
                ref_mem[ai + 3] = wd[7:0];
            end else begin
                exp_lat = 3;
                exp_rd  = 1;
                if (f3 == 3'd0) begin
                    ref_mem[ai] = wd[7:0];
                end else begin
                    ref_mem[ai]     = wd[15:8];
                    ref_mem[ai + 1] = wd[7:0];
                end
            end
            exp_wword = ref_word(ai);
        end

        check("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        // Optional stray requests while busy must be ignored.
        req_valid  = junk;
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom_range(0, c_last - 3);
        req_wdata  = $urandom;

        lat = 0; nrd = 0; nwr = 0; both = 1'b0; addr_bad = 1'b0;
        got_wword = 32'h0; rdata_at = 32'h0; err_at = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                got_wword = mem_wdata;
            end
            if (mem_read && mem_write) both = 1'b1;
            if ((mem_read || mem_write) && (mem_addr !== a)) addr_bad = 1'b1;
            if (resp_valid) begin
                lat = k;
                rdata_at = resp_rdata;
                err_at = resp_err;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;

        check("resp_latency", 32'(lat), 32'(exp_lat));
        check("resp_err", {31'h0, err_at}, {31'h0, fault});
        check("resp_rdata", rdata_at, exp_rdata);
        check("mem_read_cycles", 32'(nrd), 32'(exp_rd));
        check("mem_write_cycles", 32'(nwr), 32'(exp_wr));
        if (exp_wr != 0) check("mem_wdata", got_wword, exp_wword);
        check("rd_wr_overlap", {31'h0, both}, 32'h0);
        check("mem_addr_latched", {31'h0, addr_bad}, 32'h0);
        @(negedge clk);
        check("resp_single_pulse", {31'h0, resp_valid}, 32'h0);
        check("resp_rdata_hold", resp_rdata, exp_rdata);
        check("resp_err_hold", {31'h0, resp_err}, {31'h0, fault});
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_mem_read", {31'h0, mem_read}, 32'h0);
        check("rst_mem_write", {31'h0, mem_write}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
    endtask

    task automatic quiet_cycles(input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (resp_valid || mem_write) seen++;
        end
        check("no_activity_after_abort", 32'(seen), 32'h0);
    endtask

    initial begin
        logic [7:0] b;
        logic [31:0] ra;
        for (int i = 0; i <= c_last; i++) begin
            b = 8'($urandom);
            tb_mem[i]  = b;
            ref_mem[i] = b;
        end
        tb_mem[100] = 8'h80; tb_mem[101] = 8'h12; tb_mem[102] = 8'h34; tb_mem[103] = 8'h56;
        tb_mem[200] = 8'hDE; tb_mem[201] = 8'hAD; tb_mem[202] = 8'hBE; tb_mem[203] = 8'hEF;
        for (int i = 100; i < 104; i++) ref_mem[i] = tb_mem[i];
        for (int i = 200; i < 204; i++) ref_mem[i] = tb_mem[i];

        rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2;
        req_addr = 32'd100; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        check_reset_outputs();

        do_req(1'b0, 3'd0, 32'd100, 32'h0, 1'b0);          // LB  -> FFFFFF80
        do_req(1'b0, 3'd4, 32'd100, 32'h0, 1'b1);          // LBU -> 00000080
        do_req(1'b0, 3'd1, 32'd100, 32'h0, 1'b0);          // LH  -> FFFF8012
        do_req(1'b0, 3'd5, 32'd100, 32'h0, 1'b0);
        do_req(1'b0, 3'd2, 32'd100, 32'h0, 1'b1);
        do_req(1'b1, 3'd0, 32'd200, 32'h000000AA, 1'b0);   // SB -> AAADBEEF
        do_req(1'b1, 3'd1, 32'd104, 32'h1234BEEF, 1'b0);
        do_req(1'b1, 3'd2, 32'd200, 32'hDEADBEEF, 1'b1);
        do_req(1'b0, 3'd2, 32'd200, 32'h0, 1'b0);
        do_req(1'b0, 3'd2, 32'd5118, 32'h0, 1'b0);         // past the top
        do_req(1'b0, 3'd2, 32'd5117, 32'h0, 1'b0);         // last legal word
        do_req(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 1'b0);    // would wrap in 32 bits
        do_req(1'b0, 3'd3, 32'd100, 32'h0, 1'b0);
        do_req(1'b1, 3'd4, 32'd100, 32'h55555555, 1'b0);

        // Reset during READ of an SH: nothing reaches memory, no response.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1;
        req_addr = 32'd300; req_wdata = 32'h0000CAFE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_read_no_write", {31'h0, mem_write}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        quiet_cycles(4);

        // Reset landing on the WRITE cycle of an SW must mask the strobe.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'd400; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_write_masked", {31'h0, mem_write}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet_cycles(3);
        do_req(1'b0, 3'd2, 32'd400, 32'h0, 1'b0);
        do_req(1'b0, 3'd2, 32'd300, 32'h0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
                1:       ra = 32'($urandom_range(c_last - 6, c_last + 2));
                default: ra = 32'($urandom_range(0, 600));
            endcase
            do_req(1'($urandom), 3'($urandom), ra, $urandom, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
